// File: rtl/control_sequencer_if.sv
// Control/status bundle between the control sequencer and the single-bus datapath.
// The master side is the sequencer; the slave side is the datapath and instruction memory.
interface control_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             run;
  logic [31:0]      ir_in;
  logic             mem_ready;
  logic [4:0]       select;
  logic [15:0]      enable;
  logic             PC_enable;
  logic             MAR_enable;
  logic             IR_enable;
  logic             RY_enable;
  logic             Z_enable;
  logic             HI_enable;
  logic             LO_enable;
  logic             mdr_in;
  logic             mdr_select;
  logic             muxy_select;
  logic [4:0]       opcode;
  logic             mem_read;
  logic             halted;
  logic             fault;
  logic [CNT_W-1:0] retired;

  modport master (
    input  run, ir_in, mem_ready,
    output select, enable, PC_enable, MAR_enable, IR_enable, RY_enable, Z_enable,
           HI_enable, LO_enable, mdr_in, mdr_select, muxy_select, opcode, mem_read,
           halted, fault, retired
  );

  modport slave (
    output run, ir_in, mem_ready,
    input  select, enable, PC_enable, MAR_enable, IR_enable, RY_enable, Z_enable,
           HI_enable, LO_enable, mdr_in, mdr_select, muxy_select, opcode, mem_read,
           halted, fault, retired
  );
endinterface

// File: rtl/control_sequencer.sv
// Moore FSM sequencing fetch, decode, execute and write-back of register-format
// ALU instructions on a single-bus datapath; halts on illegal ops, faults on memory timeout.
module control_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                clear,
  control_sequencer_if.master bus
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_FETCH0   = 4'd1;
  localparam logic [3:0] S_FETCH1   = 4'd2;
  localparam logic [3:0] S_MWAIT    = 4'd3;
  localparam logic [3:0] S_MLATCH   = 4'd4;
  localparam logic [3:0] S_DECODE   = 4'd5;
  localparam logic [3:0] S_CLASSIFY = 4'd6;
  localparam logic [3:0] S_EX_A     = 4'd7;
  localparam logic [3:0] S_EX_B     = 4'd8;
  localparam logic [3:0] S_WB_LO    = 4'd9;
  localparam logic [3:0] S_WB_HI    = 4'd10;
  localparam logic [3:0] S_HALT     = 4'd11;
  localparam logic [3:0] S_FAULT    = 4'd12;

  localparam logic [4:0] SEL_ZHI  = 5'd18;
  localparam logic [4:0] SEL_ZLO  = 5'd19;
  localparam logic [4:0] SEL_PC   = 5'd20;
  localparam logic [4:0] SEL_MDR  = 5'd21;
  localparam logic [4:0] OP_INCPC = 5'h1E;
  localparam logic [7:0] TMO_LIM  = 8'(MEM_TIMEOUT);

  logic [3:0]       state_q;
  logic [3:0]       state_nx;
  logic [7:0]       tmo_q;
  logic [7:0]       tmo_inc;
  logic [CNT_W-1:0] retired_q;
  logic [4:0]       op;
  logic [3:0]       ra;
  logic [3:0]       rb;
  logic [3:0]       rc;
  logic             illegal;
  logic             unary;
  logic             hilo;
  logic             retire;

  assign op      = bus.ir_in[31:27];
  assign ra      = bus.ir_in[26:23];
  assign rb      = bus.ir_in[22:19];
  assign rc      = bus.ir_in[18:15];
  assign illegal = op[4];
  assign unary   = (op == 5'h0E) || (op == 5'h0F);
  assign hilo    = (op == 5'h0C) || (op == 5'h0D);
  assign tmo_inc = tmo_q + 8'd1;
  // Final write-back cycle: WB_HI for mul/div, WB_LO for everything writing Ra.
  assign retire  = ((state_q == S_WB_LO) && !hilo) || (state_q == S_WB_HI);

  always_comb begin
    state_nx = state_q;
    case (state_q)
      S_IDLE:     if (bus.run) state_nx = S_FETCH0;
      S_FETCH0:   state_nx = S_FETCH1;
      S_FETCH1:   state_nx = S_MWAIT;
      S_MWAIT: begin
        if (bus.mem_ready)          state_nx = S_MLATCH;
        else if (tmo_inc == TMO_LIM) state_nx = S_FAULT;
      end
      S_MLATCH:   state_nx = S_DECODE;
      S_DECODE:   state_nx = S_CLASSIFY;
      S_CLASSIFY: state_nx = illegal ? S_HALT : (unary ? S_EX_B : S_EX_A);
      S_EX_A:     state_nx = S_EX_B;
      S_EX_B:     state_nx = S_WB_LO;
      S_WB_LO:    state_nx = hilo ? S_WB_HI : (bus.run ? S_FETCH0 : S_IDLE);
      S_WB_HI:    state_nx = bus.run ? S_FETCH0 : S_IDLE;
      S_HALT:     state_nx = S_HALT;
      S_FAULT:    state_nx = S_FAULT;
      default:    state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q   <= S_IDLE;
      tmo_q     <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_nx;
      if (state_q == S_FETCH1)
        tmo_q <= '0;
      else if ((state_q == S_MWAIT) && !bus.mem_ready)
        tmo_q <= tmo_inc;
      if (retire)
        retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign bus.retired = retired_q;

  // Moore decode: a function of state_q and the already-latched IR only.
  always_comb begin
    bus.select      = '0;
    bus.enable      = '0;
    bus.PC_enable   = 1'b0;
    bus.MAR_enable  = 1'b0;
    bus.IR_enable   = 1'b0;
    bus.RY_enable   = 1'b0;
    bus.Z_enable    = 1'b0;
    bus.HI_enable   = 1'b0;
    bus.LO_enable   = 1'b0;
    bus.mdr_in      = 1'b0;
    bus.mdr_select  = 1'b0;
    bus.muxy_select = 1'b0;
    bus.opcode      = '0;
    bus.mem_read    = 1'b0;
    bus.halted      = 1'b0;
    bus.fault       = 1'b0;
    case (state_q)
      S_FETCH0: begin
        bus.select     = SEL_PC;
        bus.MAR_enable = 1'b1;
        bus.opcode     = OP_INCPC;
        bus.Z_enable   = 1'b1;
      end
      S_FETCH1: begin
        bus.select    = SEL_ZLO;
        bus.PC_enable = 1'b1;
        bus.mem_read  = 1'b1;
      end
      S_MWAIT:  bus.mem_read = 1'b1;
      S_MLATCH: begin
        bus.mem_read   = 1'b1;
        bus.mdr_select = 1'b1;
        bus.mdr_in     = 1'b1;
      end
      S_DECODE: begin
        bus.select    = SEL_MDR;
        bus.IR_enable = 1'b1;
      end
      S_EX_A: begin
        bus.select    = {1'b0, rb};
        bus.RY_enable = 1'b1;
      end
      S_EX_B: begin
        bus.select   = unary ? {1'b0, rb} : {1'b0, rc};
        bus.opcode   = op;
        bus.Z_enable = 1'b1;
      end
      S_WB_LO: begin
        bus.select = SEL_ZLO;
        if (hilo) bus.LO_enable = 1'b1;
        else      bus.enable    = 16'd1 << ra;
      end
      S_WB_HI: begin
        bus.select    = SEL_ZHI;
        bus.HI_enable = 1'b1;
      end
      S_HALT:  bus.halted = 1'b1;
      S_FAULT: begin
        bus.halted = 1'b1;
        bus.fault  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: a small single-bus datapath and memory driven by the DUT,
// plus an instruction-level model that lists the expected control word of every cycle.
`timescale 1ns/1ps
module tb_control_sequencer;
  localparam int CNT_W = 16;
  localparam int TMO   = 4;
  localparam int NEVER = 1000;
  localparam logic [4:0] OP_ADD = 5'h00, OP_SUB = 5'h01, OP_AND = 5'h02, OP_OR = 5'h03;
  localparam logic [4:0] OP_MUL = 5'h0C, OP_DIV = 5'h0D, OP_NEG = 5'h0E, OP_NOT = 5'h0F;
  localparam logic [4:0] OP_INCPC = 5'h1E;
  localparam logic [6:0] C_PC = 7'b1000000, C_MAR = 7'b0100000, C_IR = 7'b0010000;
  localparam logic [6:0] C_RY = 7'b0001000, C_Z = 7'b0000100, C_HI = 7'b0000010, C_LO = 7'b0000001;

  typedef struct packed {
    logic [4:0]       sel;
    logic [15:0]      en;
    logic [6:0]       ctl;
    logic             mdr_in;
    logic             mdr_sel;
    logic             muxy;
    logic [4:0]       opc;
    logic             mrd;
    logic             halted;
    logic             fault;
    logic [CNT_W-1:0] retired;
  } obs_t;

  logic clk = 1'b0;
  logic clear;
  always #5 clk = ~clk;

  control_sequencer_if #(.CNT_W(CNT_W)) sif ();
  control_sequencer #(.MEM_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (.clk(clk), .clear(clear), .bus(sif));

  int checks;
  int errors;

  // Datapath registers and instruction memory
  logic [31:0] rf [16];
  logic [31:0] pre_rf [16];
  logic [31:0] mem [16];
  logic [31:0] pc, mar, mdr, ir_q, ry, hi, lo, bus_v, pre_pc;
  logic [63:0] z;
  logic        pre_go;
  int          wait_q [$];

  function automatic logic [63:0] alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_ADD:   return {32'b0, a + b};
      OP_SUB:   return {32'b0, a - b};
      OP_AND:   return {32'b0, a & b};
      OP_OR:    return {32'b0, a | b};
      OP_MUL:   return {32'b0, a} * {32'b0, b};
      OP_DIV:   return (b == 32'd0) ? 64'd0 : {a % b, a / b};
      OP_NEG:   return {32'b0, -b};
      OP_NOT:   return {32'b0, ~b};
      OP_INCPC: return {32'b0, b + 32'd1};
      default:  return {32'b0, a + b};
    endcase
  endfunction

  always_comb begin
    bus_v = '0;
    if (sif.select < 5'd16) bus_v = rf[sif.select[3:0]];
    else case (sif.select)
      5'd16:   bus_v = hi;
      5'd17:   bus_v = lo;
      5'd18:   bus_v = z[63:32];
      5'd19:   bus_v = z[31:0];
      5'd20:   bus_v = pc;
      5'd21:   bus_v = mdr;
      default: bus_v = '0;
    endcase
  end

  always @(posedge clk) begin
    if (pre_go) begin
      for (int i = 0; i < 16; i++) rf[i] <= pre_rf[i];
      pc <= pre_pc;
    end else begin
      for (int i = 0; i < 16; i++) if (sif.enable[i]) rf[i] <= bus_v;
      if (sif.PC_enable)  pc   <= bus_v;
      if (sif.MAR_enable) mar  <= bus_v;
      if (sif.IR_enable)  ir_q <= bus_v;
      if (sif.RY_enable)  ry   <= bus_v;
      if (sif.HI_enable)  hi   <= bus_v;
      if (sif.LO_enable)  lo   <= bus_v;
      if (sif.Z_enable)   z    <= alu(sif.opcode, ry, bus_v);
      if (sif.mdr_in)     mdr  <= sif.mdr_select ? mem[mar[3:0]] : bus_v;
    end
  end

  assign sif.ir_in = ir_q;

  // Memory responder: raises mem_ready after the given number of unanswered MWAIT cycles
  int rd_cycles;
  int cur_wait;
  initial begin
    sif.mem_ready = 1'b0;
    rd_cycles = 0;
    cur_wait = NEVER;
    forever begin
      @(negedge clk);
      if (sif.mem_read) begin
        if (rd_cycles == 0) cur_wait = (wait_q.size() > 0) ? wait_q.pop_front() : NEVER;
        rd_cycles++;
      end else begin
        rd_cycles = 0;
      end
      sif.mem_ready = sif.mem_read && (rd_cycles >= cur_wait + 2);
    end
  end

  // Instruction-level expectation model
  obs_t  exp_q [$];
  string tag_q [$];
  int    exp_ret;

  function automatic obs_t blank();
    obs_t o;
    o = '0;
    o.retired = CNT_W'(exp_ret);
    return o;
  endfunction

  task automatic push(input obs_t o, input string t);
    exp_q.push_back(o);
    tag_q.push_back(t);
  endtask

  task automatic push_fetch(input int nw);
    obs_t o;
    o = blank(); o.sel = 5'd20; o.ctl = C_MAR | C_Z; o.opc = OP_INCPC; push(o, "FETCH0");
    o = blank(); o.sel = 5'd19; o.ctl = C_PC; o.mrd = 1'b1; push(o, "FETCH1");
    for (int i = 0; i < nw; i++) begin
      o = blank(); o.mrd = 1'b1; push(o, "MWAIT");
    end
  endtask

  task automatic push_instr(input logic [31:0] ir, input int waits);
    obs_t o;
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    logic unary, hilo;
    op = ir[31:27]; ra = ir[26:23]; rb = ir[22:19]; rc = ir[18:15];
    unary = (op == OP_NEG) || (op == OP_NOT);
    hilo  = (op == OP_MUL) || (op == OP_DIV);
    if (waits >= TMO) begin
      push_fetch(TMO);
      for (int i = 0; i < 3; i++) begin
        o = blank(); o.halted = 1'b1; o.fault = 1'b1; push(o, "FAULT");
      end
      return;
    end
    push_fetch(waits + 1);
    o = blank(); o.mrd = 1'b1; o.mdr_in = 1'b1; o.mdr_sel = 1'b1; push(o, "MLATCH");
    o = blank(); o.sel = 5'd21; o.ctl = C_IR; push(o, "DECODE");
    o = blank(); push(o, "CLASSIFY");
    if (op >= 5'h10) begin
      for (int i = 0; i < 3; i++) begin
        o = blank(); o.halted = 1'b1; push(o, "HALT");
      end
      return;
    end
    if (!unary) begin
      o = blank(); o.sel = {1'b0, rb}; o.ctl = C_RY; push(o, "EX_A");
    end
    o = blank(); o.sel = unary ? {1'b0, rb} : {1'b0, rc}; o.opc = op; o.ctl = C_Z; push(o, "EX_B");
    o = blank(); o.sel = 5'd19;
    if (hilo) o.ctl = C_LO;
    else o.en = 16'd1 << ra;
    push(o, "WB_LO");
    if (hilo) begin
      o = blank(); o.sel = 5'd18; o.ctl = C_HI; push(o, "WB_HI");
    end
    exp_ret++;
  endtask

  function automatic obs_t sample();
    obs_t a;
    a.sel = sif.select; a.en = sif.enable;
    a.ctl = {sif.PC_enable, sif.MAR_enable, sif.IR_enable, sif.RY_enable,
             sif.Z_enable, sif.HI_enable, sif.LO_enable};
    a.mdr_in = sif.mdr_in; a.mdr_sel = sif.mdr_select; a.muxy = sif.muxy_select;
    a.opc = sif.opcode; a.mrd = sif.mem_read; a.halted = sif.halted; a.fault = sif.fault;
    a.retired = sif.retired;
    return a;
  endfunction

  // Per-cycle compare against the model's trace
  initial begin
    obs_t  e, a;
    string t;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        a = sample();
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL trace %s @%0t: got %h expected %h", t, $time, a, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    tick(); clear = 1'b1; sif.run = 1'b0; pre_go = 1'b1; wait_q.delete();
    tick(); clear = 1'b0; pre_go = 1'b0; exp_ret = 0;
  endtask

  task automatic preload();
    pre_go = 1'b1;
    tick();
    pre_go = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s drain: %0d trace entries left, expected 0", name, exp_q.size());
      exp_q.delete();
      tag_q.delete();
    end
  endtask

  task automatic start_one(input logic [31:0] ir, input int waits);
    push(blank(), "IDLE");
    push_instr(ir, waits);
    push(blank(), "IDLE");
    wait_q.push_back(waits);
    sif.run = 1'b1;
    tick();
    sif.run = 1'b0;
  endtask

  function automatic logic [31:0] enc(input logic [4:0] op, input logic [3:0] ra,
                                      input logic [3:0] rb, input logic [3:0] rc);
    return {op, ra, rb, rc, 15'b0};
  endfunction

  initial begin
    clear = 1'b0; sif.run = 1'b0; pre_go = 1'b0;
    checks = 0; errors = 0; exp_ret = 0; pre_pc = '0;
    for (int i = 0; i < 16; i++) begin pre_rf[i] = '0; mem[i] = '0; end

    // Idle after reset
    do_clear();
    for (int i = 0; i < 3; i++) push(blank(), "IDLE");
    wait_drain(10, "idle");
    chk("reset retired", 64'(sif.retired), 64'd0);

    // add R3,R1,R2 with two unanswered MWAIT cycles
    pre_rf[1] = 32'd5; pre_rf[2] = 32'd7; pre_pc = 32'd0;
    mem[0] = enc(OP_ADD, 4'd3, 4'd1, 4'd2);
    do_clear();
    start_one(mem[0], 2);
    wait_drain(40, "add");
    chk("add R3", 64'(rf[3]), 64'd12);
    chk("add PC", 64'(pc), 64'd1);
    chk("add retired", 64'(sif.retired), 64'd1);

    // mul R1,R2
    pre_rf[1] = 32'h0001_0000; pre_rf[2] = 32'h0003_0000; pre_pc = 32'd0;
    mem[0] = enc(OP_MUL, 4'd0, 4'd1, 4'd2);
    preload();
    start_one(mem[0], 0);
    wait_drain(40, "mul");
    chk("mul HI", 64'(hi), 64'd3);
    chk("mul LO", 64'(lo), 64'd0);
    chk("mul retired", 64'(sif.retired), 64'd2);

    // not R4,R5
    pre_rf[5] = 32'h0F0F_0F0F; pre_pc = 32'd0;
    mem[0] = enc(OP_NOT, 4'd4, 4'd5, 4'd0);
    preload();
    start_one(mem[0], 1);
    wait_drain(40, "not");
    chk("not R4", 64'(rf[4]), 64'hF0F0_F0F0);
    chk("not retired", 64'(sif.retired), 64'd3);

    // clear while waiting on memory
    push(blank(), "IDLE");
    push_fetch(2);
    exp_ret = 0;
    push(blank(), "IDLE after clear");
    push(blank(), "IDLE after clear");
    wait_q.push_back(NEVER);
    sif.run = 1'b1; tick(); sif.run = 1'b0;
    tick(); tick(); tick();
    clear = 1'b1; tick(); clear = 1'b0;
    chk("clear mem_read", 64'(sif.mem_read), 64'd0);
    chk("clear retired", 64'(sif.retired), 64'd0);
    wait_drain(10, "clear");

    // back-to-back sub/or, first fetch answered on the last MWAIT before timeout
    pre_rf[7] = 32'd20; pre_rf[8] = 32'd3; pre_rf[10] = 32'h100; pre_pc = 32'd0;
    mem[0] = enc(OP_SUB, 4'd6, 4'd7, 4'd8);
    mem[1] = enc(OP_OR, 4'd9, 4'd6, 4'd10);
    preload();
    push(blank(), "IDLE");
    push_instr(mem[0], 3);
    push_instr(mem[1], 0);
    push(blank(), "IDLE");
    wait_q.push_back(3); wait_q.push_back(0);
    sif.run = 1'b1;
    repeat (16) tick();
    sif.run = 1'b0;
    wait_drain(40, "chain");
    chk("sub R6", 64'(rf[6]), 64'd17);
    chk("or R9", 64'(rf[9]), 64'h111);
    chk("chain PC", 64'(pc), 64'd2);
    chk("chain retired", 64'(sif.retired), 64'd2);

    // illegal opcode halts with run held high
    pre_pc = 32'd0;
    mem[0] = enc(5'h15, 4'd1, 4'd2, 4'd3);
    preload();
    push(blank(), "IDLE");
    push_instr(mem[0], 0);
    wait_q.push_back(0);
    sif.run = 1'b1;
    wait_drain(40, "halt");
    repeat (5) tick();
    chk("halt halted", 64'(sif.halted), 64'd1);
    chk("halt fault", 64'(sif.fault), 64'd0);
    chk("halt PC", 64'(pc), 64'd1);
    chk("halt retired", 64'(sif.retired), 64'd2);
    do_clear();
    chk("halt cleared", 64'(sif.halted), 64'd0);

    // memory never answers
    mem[0] = enc(OP_ADD, 4'd1, 4'd1, 4'd1);
    push(blank(), "IDLE");
    push_instr(mem[0], NEVER);
    wait_q.push_back(NEVER);
    sif.run = 1'b1;
    wait_drain(40, "fault");
    chk("fault fault", 64'(sif.fault), 64'd1);
    chk("fault halted", 64'(sif.halted), 64'd1);
    chk("fault mem_read", 64'(sif.mem_read), 64'd0);
    do_clear();
    chk("fault cleared", 64'(sif.fault), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
